uart_tx_arb: RTL and testbench

//  Round-robin arbiter that shares one uart_tx instance between N_REQ byte-stream requesters.

---
 rtl/uart_tx_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing one uart_tx between N_REQ byte-stream producers.
// A requester owns the line from the first byte of a packet until its last
// byte has left the transmitter, so packets never interleave. A stalled
// owner is force-released after PKT_TIMEOUT idle cycles inside a packet.
//
// Ports
//   i_sys_clk    system clock
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester byte valid             [N_REQ]
//   i_req_data   per-requester byte, req k = [k*8+:8] [N_REQ*8]
//   i_req_last   per-requester last-of-packet flag    [N_REQ]
//   o_req_ready  per-requester ready (combinational)  [N_REQ]
//   o_grant      one-hot current owner, 0 when idle   [N_REQ]
//   o_timeout    1-cycle pulse on forced release
//   o_send_en    1-cycle start pulse to uart_tx
//   o_send_data  byte to uart_tx, held until the next byte
//   i_send_busy  uart_tx busy
// -----------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int N_REQ       = 4,
    parameter int BUSY_WAIT   = 4,
    parameter int PKT_TIMEOUT = 1024
) (
    input  logic               i_sys_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ*8-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_timeout,
    output logic               o_send_en,
    output logic [7:0]         o_send_data,
    input  logic               i_send_busy
);

    localparam int IDXW = $clog2(N_REQ);
    localparam int ICW  = $clog2(PKT_TIMEOUT);

    localparam logic [IDXW-1:0] PTR_RST  = IDXW'(N_REQ - 1);
    localparam logic [3:0]      WAIT_MAX = 4'(BUSY_WAIT - 1);
    localparam logic [ICW-1:0]  IDLE_MAX = ICW'(PKT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_e;

    state_e            state_q,     state_d;
    logic [N_REQ-1:0]  grant_q,     grant_d;
    logic [IDXW-1:0]   gidx_q,      gidx_d;
    logic [IDXW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic              last_q,      last_d;
    logic              send_en_q,   send_en_d;
    logic [7:0]        send_data_q, send_data_d;
    logic              timeout_q,   timeout_d;
    logic [3:0]        wait_cnt_q,  wait_cnt_d;
    logic [ICW-1:0]    idle_cnt_q,  idle_cnt_d;

    logic [IDXW-1:0]   pick_s;
    logic              valid_g_s;
    logic              last_g_s;
    logic [7:0]        data_g_s;

    // First requesting index strictly after ptr, wrapping; the previous
    // owner (ptr) is therefore considered last.
    function automatic logic [IDXW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDXW-1:0]  ptr);
        logic [IDXW-1:0] idx;
        logic            found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDXW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    // Owner-side views of the request bus and the round-robin winner.
    always_comb begin
        pick_s    = rr_pick(i_req_valid, rr_ptr_q);
        valid_g_s = |(i_req_valid & grant_q);
        last_g_s  = |(i_req_last & grant_q);
        data_g_s  = i_req_data[{gidx_q, 3'b000} +: 8];
    end

    // Ready is only offered to the owner while the transmitter is free.
    always_comb begin
        if ((state_q == ST_LOAD) && !i_send_busy) begin
            o_req_ready = grant_q;
        end else begin
            o_req_ready = '0;
        end
    end

    // Next-state logic for the arbitration / byte hand-off FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        last_d      = last_q;
        send_en_d   = 1'b0;
        send_data_d = send_data_q;
        timeout_d   = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        idle_cnt_d  = idle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    gidx_d     = pick_s;
                    grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
                    idle_cnt_d = '0;
                    state_d    = ST_LOAD;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (valid_g_s && !i_send_busy) begin
                    send_data_d = data_g_s;
                    send_en_d   = 1'b1;
                    last_d      = last_g_s;
                    idle_cnt_d  = '0;
                    wait_cnt_d  = 4'd0;
                    state_d     = ST_WAIT_HI;
                end else if (!valid_g_s) begin
                    // Idle gap inside a packet; counter stops at its limit.
                    if (idle_cnt_q == IDLE_MAX) begin
                        timeout_d = 1'b1;
                        grant_d   = '0;
                        rr_ptr_d  = gidx_q;
                        state_d   = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + {{(ICW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    // Byte offered but transmitter still busy: just hold.
                    state_d = ST_LOAD;
                end
            end

            ST_WAIT_HI: begin
                if (i_send_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (wait_cnt_q >= WAIT_MAX) begin
                    // uart_tx never acknowledged: treat the byte as sent so
                    // a missing busy cannot deadlock the arbiter.
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = gidx_q;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_LOAD;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            ST_WAIT_LO: begin
                if (!i_send_busy) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = gidx_q;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_LOAD;
                    end
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= PTR_RST;
            last_q      <= 1'b0;
            send_en_q   <= 1'b0;
            send_data_q <= 8'h00;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= 4'd0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            last_q      <= last_d;
            send_en_q   <= send_en_d;
            send_data_q <= send_data_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_timeout   = timeout_q;
    assign o_send_en   = send_en_q;
    assign o_send_data = send_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb. Producers are byte queues per
// requester; a simple uart_tx model raises busy for a configurable time.
// Expected byte order comes from a packet-level round-robin model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int PT = 16;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   i_req_valid = '0;
    logic [N*8-1:0] i_req_data  = '0;
    logic [N-1:0]   i_req_last  = '0;
    logic           i_send_busy = 1'b0;
    logic [N-1:0]   o_req_ready;
    logic [N-1:0]   o_grant;
    logic           o_timeout;
    logic           o_send_en;
    logic [7:0]     o_send_data;

    uart_tx_arb #(.N_REQ(N), .BUSY_WAIT(BW), .PKT_TIMEOUT(PT)) dut (
        .i_sys_clk   (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_timeout   (o_timeout),
        .o_send_en   (o_send_en),
        .o_send_data (o_send_data),
        .i_send_busy (i_send_busy)
    );

    always #5 clk = ~clk;

    logic [8:0] q  [N][$];   // bytes still to be offered, bit 8 = last
    logic [8:0] mq [N][$];   // model copy of every pushed byte
    int obs_req[$], obs_data[$], obs_cyc[$];
    int exp_req[$], exp_data[$];

    int cyc = 0;
    int vstart[N];
    int bfall_cyc = -1, gdrop_cyc = -1;
    int tout_cnt = 0, tout_delta = -1, tout_gnt = -1;
    int busy_cnt = 0, busy_len = 10;
    bit pend = 1'b0, no_busy = 1'b0;
    logic [N-1:0] gprev = '0, vprev = '0;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        idx_of = -1;
        for (int i = 0; i < N; i++) if (g[i]) idx_of = i;
    endfunction

    // Producer + uart_tx model: sample at negedge, update drives after posedge.
    initial begin : bfm
        logic [N-1:0] fire;
        logic [8:0]   h;
        forever begin
            @(negedge clk);
            fire = i_req_valid & o_req_ready;
            if (rst_n) begin
                chk("grant_onehot", {31'd0, $onehot0(o_grant)}, 32'd1);
                chk("ready_in_grant", {31'd0, |(o_req_ready & ~o_grant)}, 32'd0);
                if (o_send_en) begin
                    obs_req.push_back(idx_of(o_grant));
                    obs_data.push_back(int'(o_send_data));
                    obs_cyc.push_back(cyc);
                    if (!no_busy) pend = 1'b1;
                end
                if (o_timeout) begin
                    tout_cnt++;
                    tout_delta = cyc - bfall_cyc;
                    tout_gnt   = int'(o_grant);
                end
                if (gprev != '0 && o_grant == '0) gdrop_cyc = cyc;
            end
            gprev = o_grant;
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < N; k++)
                if (fire[k] && q[k].size() > 0) void'(q[k].pop_front());
            if (!rst_n) begin
                busy_cnt = 0;
                pend     = 1'b0;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (pend) begin
                    busy_cnt = busy_len;
                    pend     = 1'b0;
                end
            end
            if (i_send_busy && busy_cnt == 0) bfall_cyc = cyc;
            i_send_busy = (busy_cnt > 0);
            for (int k = 0; k < N; k++) begin
                if (q[k].size() > 0) begin
                    h = q[k][0];
                    i_req_valid[k]       = 1'b1;
                    i_req_data[k*8 +: 8] = h[7:0];
                    i_req_last[k]        = h[8];
                end else begin
                    i_req_valid[k]       = 1'b0;
                    i_req_data[k*8 +: 8] = 8'h00;
                    i_req_last[k]        = 1'b0;
                end
                if (i_req_valid[k] && !vprev[k]) vstart[k] = cyc;
            end
            vprev = i_req_valid;
        end
    end

    task automatic push_byte(input int k, input int d, input bit last);
        q[k].push_back({last, 8'(d)});
        mq[k].push_back({last, 8'(d)});
    endtask

    task automatic clear_all;
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            mq[k].delete();
        end
        obs_req.delete(); obs_data.delete(); obs_cyc.delete();
        exp_req.delete(); exp_data.delete();
        tout_cnt = 0; tout_delta = -1; tout_gnt = -1;
        gdrop_cyc = -1; bfall_cyc = -1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Packet-level model: owner after reset is N-1; each packet goes whole
    // to the next requester (after the previous owner) holding data.
    task automatic build_exp;
        int ptr, k;
        logic [8:0] b;
        ptr = N - 1;
        exp_req.delete(); exp_data.delete();
        do begin
            k = -1;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (ptr + i) % N;
                if (k < 0 && mq[c].size() > 0) k = c;
            end
            if (k >= 0) begin
                do begin
                    b = mq[k].pop_front();
                    exp_req.push_back(k);
                    exp_data.push_back(int'(b[7:0]));
                end while (!b[8] && mq[k].size() > 0);
                ptr = k;
            end
        end while (k >= 0);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        bit empty;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            empty = 1'b1;
            for (int k = 0; k < N; k++) if (q[k].size() > 0) empty = 1'b0;
        end while (!(empty && o_grant == '0 && !i_send_busy) && n < bound);
        chk({tag, "_done"}, {31'd0, n < bound}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_log(input string tag);
        chk({tag, "_nbytes"}, obs_req.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < obs_req.size(); i++) begin
            chk({tag, "_owner"}, obs_req[i], exp_req[i]);
            chk({tag, "_data"},  obs_data[i], exp_data[i]);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_grant"},   o_grant,     '0);
        chk({tag, "_ready"},   o_req_ready, '0);
        chk({tag, "_senden"},  o_send_en,   '0);
        chk({tag, "_sdata"},   o_send_data, '0);
        chk({tag, "_timeout"}, o_timeout,   '0);
    endtask

    initial begin : main
        int n;
        repeat (3) @(negedge clk);
        chk_outputs_zero("rst");
        rst_n = 1'b1;

        // 1: three-byte packet from req0
        do_reset();
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        build_exp();
        wait_idle("t1", 500);
        compare_log("t1");
        if (obs_cyc.size() > 0) chk("t1_latency", obs_cyc[0] - vstart[0], 32'd2);
        chk("t1_release", gdrop_cyc - bfall_cyc, 32'd1);

        // 2: three requesters, two single-byte packets each
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) push_byte(k, 16 * (k + 1) + r, 1'b1);
        build_exp();
        wait_idle("t2", 800);
        compare_log("t2");
        for (int i = 0; i < obs_req.size(); i++) chk("t2_order", obs_req[i], i % 3);

        // 3: req0 arrives while req1 is mid-packet
        do_reset();
        for (int b = 0; b < 4; b++) q[1].push_back({b == 3, 8'(8'hB0 + b)});
        n = 0;
        while (obs_req.size() < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t3_reach", {31'd0, n < 300}, 32'd1);
        q[0].push_back({1'b1, 8'h77});
        wait_idle("t3", 800);
        for (int b = 0; b < 4; b++) begin
            exp_req.push_back(1);
            exp_data.push_back(8'hB0 + b);
        end
        exp_req.push_back(0);
        exp_data.push_back(8'h77);
        compare_log("t3");

        // 4: req2 stalls inside a packet, timeout releases it, req3 served
        do_reset();
        q[2].push_back({1'b0, 8'h22});
        q[3].push_back({1'b1, 8'h33});
        wait_idle("t4", 500);
        exp_req.push_back(2); exp_data.push_back(8'h22);
        exp_req.push_back(3); exp_data.push_back(8'h33);
        compare_log("t4");
        chk("t4_tout_cnt", tout_cnt, 32'd1);
        chk("t4_tout_delay", tout_delta, PT + 1);
        chk("t4_tout_grant", tout_gnt, 32'd0);

        // 5: transmitter never asserts busy
        do_reset();
        no_busy = 1'b1;
        push_byte(0, 8'h51, 1'b0);
        push_byte(0, 8'h52, 1'b0);
        push_byte(0, 8'h53, 1'b1);
        build_exp();
        wait_idle("t5", 300);
        compare_log("t5");
        if (obs_cyc.size() == 3) begin
            chk("t5_gap1", obs_cyc[1] - obs_cyc[0], BW + 1);
            chk("t5_gap2", obs_cyc[2] - obs_cyc[1], BW + 1);
            chk("t5_release", gdrop_cyc - obs_cyc[2], BW);
        end
        no_busy = 1'b0;

        // 6: reset while waiting for busy to fall
        do_reset();
        busy_len = 10;
        push_byte(3, 8'hA5, 1'b0);
        push_byte(3, 8'hA6, 1'b1);
        n = 0;
        while (!(obs_req.size() >= 1 && i_send_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach", {31'd0, n < 200}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_async");
        clear_all();
        push_byte(3, 8'h33, 1'b1);
        push_byte(0, 8'h30, 1'b1);
        build_exp();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle("t6", 500);
        compare_log("t6");

        // 7: random packet mixes and transmitter busy times
        for (int r = 0; r < 6; r++) begin
            do_reset();
            busy_len = $urandom_range(1, 12);
            for (int k = 0; k < N; k++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        push_byte(k, $urandom_range(0, 255), b == len - 1);
                end
            end
            build_exp();
            wait_idle("t7", 4000);
            compare_log("t7");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
